pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Two-entry elastic pipeline register with a valid/ready handshake on both sides, used between processor pipeline stages. Upstream writes, downstream reads; the block decouples them so that a registered `o_ready` never costs throughput. It replaces the plain enabled register wherever a stage must stall without dropping data, and supports a single-cycle flush for branch/exception squash.

## Interface
- `DATA_WIDTH`, 32, width of the data path in bits

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `i_flush`  in  1  discard all held entries (squash)
- `i_valid`  in  1  upstream offers `i_data`
- `i_data`  in  DATA_WIDTH  upstream payload
- `o_ready`  out  1  block can accept an upstream word this cycle
- `o_valid`  out  1  `o_data` holds a valid word
- `o_data`  out  DATA_WIDTH  downstream payload (output register)
- `i_ready`  in  1  downstream accepts `o_data` this cycle
- `o_count`  out  2  number of held words, 0..2

## Operation
- Storage: output register `out_q` (drives `o_data`) and skid register `skid_q`.
- Transfer rules: input fire = `i_valid && o_ready`; output fire = `o_valid && i_ready`.
- States: EMPTY (count 0), BUSY (count 1, word in `out_q`), FULL (count 2, oldest in `out_q`, newest in `skid_q`).
- EMPTY: input fire -> `out_q <= i_data`, go BUSY; else stay.
- BUSY: in+out fire -> `out_q <= i_data`, stay BUSY; in only -> `skid_q <= i_data`, go FULL; out only -> EMPTY; neither -> stay.
- FULL: out fire -> `out_q <= skid_q`, go BUSY; else stay. No input fire possible (`o_ready`=0).
- `o_valid` = state != EMPTY; `o_ready` = `rst` && state != FULL; `o_count` = 0/1/2 per state. All are decoded from registered state only; no combinational path from `i_ready` or `i_valid` to any output.
- Order preserved strictly FIFO; no word duplicated or dropped except by flush/reset.
- `i_flush`=1: next state EMPTY regardless of handshakes; any same-cycle input fire is discarded; `out_q`/`skid_q` contents hold (don't-care, not observable since `o_valid`=0).
- Priority: `rst` low > `i_flush` > handshake transitions.
- `i_data` changes while `o_ready`=0 have no effect.

## Timing
- Reset (`rst`=0 at a rising edge): state EMPTY, `out_q`=0, `skid_q`=0. While `rst` is low: `o_valid`=0, `o_ready`=0, `o_count`=0, `o_data`=0 after the first edge.
- First edge with `rst`=1: `o_ready`=1; word accepted on that edge appears on `o_data` with `o_valid`=1 immediately after it (latency 1 cycle).
- Throughput: 1 word/cycle sustained when `i_ready`=1 continuously.
- Downstream stall: first word held in `out_q`, second captured in `skid_q`, `o_ready` drops the cycle after the second capture; no word is lost.
- Stall release from FULL: `o_ready` returns to 1 the cycle after the output fire.
- Flush: `o_valid`=0 and `o_ready`=1 the cycle after the flush edge.
- Reset mid-operation: held words discarded, identical to power-on reset.

## Test plan
- Reset: hold `rst`=0 three cycles with `i_valid`=1, `i_data`=8'hA5 (DATA_WIDTH=8) -> `o_valid`=0, `o_ready`=0, `o_data`=8'h00, `o_count`=0 throughout.
- Streaming: `i_ready`=1, drive 8'h01..8'h10 one per cycle -> same sequence on `o_data`, each one cycle later, `o_ready` never 0.
- Stall/fill: `i_ready`=0, offer 8'hA5, 8'h3C, 8'hFF -> A5 and 3C accepted, `o_count`=2, `o_ready`=0, FF held off; raise `i_ready` -> outputs A5, 3C, FF in order.
- Simultaneous in/out in BUSY: `out_q`=8'h55, `i_valid`=`i_ready`=1 with 8'h66 -> next cycle `o_data`=8'h66, `o_count`=1.
- Flush in FULL with `i_valid`=1, `i_data`=8'h77 -> next cycle `o_valid`=0, `o_count`=0, `o_ready`=1; 8'h77 never appears on `o_data`.
- Random: random `i_valid`/`i_ready`/`i_flush` for 10k cycles against a FIFO scoreboard model -> no loss, reorder, or duplication; `o_count` matches model.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register with squash; 1-cycle latency, 1 word/cycle sustained.
// Backpressure: o_ready is decoded from registered state only and drops only while both entries are held.
module pipe_skid_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  // State encoding doubles as the held-word count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, skid_q;
  logic                  in_fire, out_fire;
  logic                  load_out, out_from_skid, load_skid;

  assign o_valid  = (state_q != ST_EMPTY);
  assign o_ready  = rst && (state_q != ST_FULL);
  assign o_count  = state_q;
  assign o_data   = out_q;
  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          load_out = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          load_out = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          load_out      = 1'b1;
          out_from_skid = 1'b1;
          state_d       = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Squash wins over any handshake; stale data stays put but is never marked valid.
    if (i_flush) begin
      state_d   = ST_EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_out)  out_q  <= out_from_skid ? skid_q : i_data;
      if (load_skid) skid_q <= i_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus a random run against a queue scoreboard.
module tb_pipe_skid_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         i_flush;
  logic         i_valid;
  logic [W-1:0] i_data;
  logic         o_ready;
  logic         i_ready;
  logic         o_valid;
  logic [W-1:0] o_data;
  logic [1:0]   o_count;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q[$];

  pipe_skid_reg #(.DATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_count (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the scoreboard mid-cycle,
  // then advance the scoreboard by the handshakes that happen on the coming edge.
  task automatic cyc(input logic r, input logic fl, input logic v, input logic [W-1:0] d,
                     input logic rdy);
    logic in_f, out_f;
    rst     = r;
    i_flush = fl;
    i_valid = v;
    i_data  = d;
    i_ready = rdy;
    @(negedge clk);
    check("o_valid", 32'(o_valid), 32'(sb_q.size() != 0));
    check("o_count", 32'(o_count), 32'(sb_q.size()));
    check("o_ready", 32'(o_ready), 32'(r && (sb_q.size() < 2)));
    in_f  = v && r && (sb_q.size() < 2);
    out_f = (sb_q.size() != 0) && rdy;
    if (!r) begin
      sb_q.delete();
    end else begin
      if (out_f) check("o_data", 32'(o_data), 32'(sb_q.pop_front()));
      if (fl) sb_q.delete();
      else if (in_f) sb_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'hA5;
    i_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with traffic offered
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
      check("rst_o_data", 32'(o_data), 32'h0);
    end

    // Streaming 01..10
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 1'b1, W'(i), 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Stall and fill, FF held off until space frees
    cyc(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
    check("full_count", 32'(o_count), 32'd2);
    check("full_ready", 32'(o_ready), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Simultaneous in/out in BUSY
    cyc(1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h66, 1'b1);
    check("busy_swap_data", 32'(o_data), 32'h66);
    check("busy_swap_count", 32'(o_count), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Flush from FULL with a word offered
    cyc(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_ready", 32'(o_ready), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'h88, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic, flushes and occasional mid-run reset
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) != 0),
          W'($urandom),
          ($urandom_range(0, 2) != 0));
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
